// File: rtl/code_gen.sv
// GPS C/A replica code generator: G1/G2 Gold code, half-chip counter, E/P/L taps, epoch dump and code slew.
// Latency: outputs registered one clk after the strobe; no backpressure (strobe driven, always ready).
// Optional CODE_GEN_PHASE_LATCH_EN: code_phase updates only on tic_enable instead of tracking the counter.
module code_gen #(
    parameter int HALF_CHIPS = 2046
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tic_enable,
    input  logic        hc_enable,
    input  logic        prn_key_enable,
    input  logic [9:0]  prn_key,
    input  logic [10:0] code_slew,
    input  logic        slew_enable,
    output logic        dump_enable,
    output logic [10:0] code_phase,
    output logic        fc_enable,
    output logic        early,
    output logic        prompt,
    output logic        late
);
    localparam logic [10:0] LAST_HC  = 11'(HALF_CHIPS - 1);
    localparam logic [10:0] MAX_SLEW = 11'(HALF_CHIPS);

    logic [9:0]  g1;
    logic [9:0]  g2;
    logic [9:0]  key;
    logic [10:0] hc_cnt;
    logic [10:0] slew_pend;
    logic        slew_pend_vld;
    logic [10:0] hold_cnt;

    logic        chip;
    logic        hc_run;
    logic        wrap;
    logic        chip_step;
    logic [10:0] slew_clamped;

    always_comb begin
        chip         = g1[0] ^ g2[0];
        hc_run       = hc_enable && (hold_cnt == 11'd0);
        wrap         = hc_run && (hc_cnt == LAST_HC);
        chip_step    = hc_run && hc_cnt[0];
        slew_clamped = (code_slew > MAX_SLEW) ? MAX_SLEW : code_slew;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            g1            <= 10'h3FF;
            g2            <= 10'h000;
            key           <= 10'h000;
            hc_cnt        <= 11'd0;
            slew_pend     <= 11'd0;
            slew_pend_vld <= 1'b0;
            hold_cnt      <= 11'd0;
            dump_enable   <= 1'b0;
            fc_enable     <= 1'b0;
            early         <= 1'b0;
            prompt        <= 1'b0;
            late          <= 1'b0;
        end else if (prn_key_enable) begin
            key           <= prn_key;
            g2            <= prn_key;
            g1            <= 10'h3FF;
            hc_cnt        <= 11'd0;
            slew_pend_vld <= 1'b0;
            hold_cnt      <= 11'd0;
            dump_enable   <= 1'b0;
            fc_enable     <= 1'b0;
        end else begin
            dump_enable <= wrap;
            fc_enable   <= chip_step;

            // Held half-chips are swallowed entirely: nothing but the hold count moves.
            if (hc_enable && (hold_cnt != 11'd0))
                hold_cnt <= hold_cnt - 11'd1;

            if (hc_run) begin
                early  <= chip;
                prompt <= early;
                late   <= prompt;
            end

            if (wrap) begin
                hc_cnt <= 11'd0;
                g1     <= 10'h3FF;
                g2     <= key;
            end else if (hc_run) begin
                hc_cnt <= hc_cnt + 11'd1;
                if (hc_cnt[0]) begin
                    g1 <= {g1[7] ^ g1[0], g1[9:1]};
                    g2 <= {g2[8] ^ g2[7] ^ g2[4] ^ g2[2] ^ g2[1] ^ g2[0], g2[9:1]};
                end
            end

            // The dump consumes the old pending slew before a coincident request becomes the new one.
            if (wrap && slew_pend_vld)
                hold_cnt <= slew_pend;

            if (slew_enable) begin
                slew_pend_vld <= 1'b1;
                slew_pend     <= slew_clamped;
            end else if (wrap) begin
                slew_pend_vld <= 1'b0;
            end
        end
    end

`ifdef CODE_GEN_PHASE_LATCH_EN
    logic [10:0] phase_q;

    always_ff @(posedge clk) begin
        if (rstn)
            phase_q <= 11'd0;
        else if (tic_enable)
            phase_q <= hc_cnt;
    end

    assign code_phase = phase_q;
`else
    logic tic_unused;

    assign tic_unused = tic_enable;
    assign code_phase = hc_cnt;
`endif

endmodule

// File: tb/tb_code_gen.sv
// Randomized and directed bench for code_gen against a table-driven reference of the C/A code.
module tb_code_gen;
    localparam int HC = 2046;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        tic_enable = 1'b0;
    logic        hc_enable = 1'b0;
    logic        prn_key_enable = 1'b0;
    logic [9:0]  prn_key = 10'h000;
    logic [10:0] code_slew = 11'd0;
    logic        slew_enable = 1'b0;
    logic        dump_enable;
    logic [10:0] code_phase;
    logic        fc_enable;
    logic        early;
    logic        prompt;
    logic        late;

    code_gen dut (
        .clk            (clk),
        .rstn           (rstn),
        .tic_enable     (tic_enable),
        .hc_enable      (hc_enable),
        .prn_key_enable (prn_key_enable),
        .prn_key        (prn_key),
        .code_slew      (code_slew),
        .slew_enable    (slew_enable),
        .dump_enable    (dump_enable),
        .code_phase     (code_phase),
        .fc_enable      (fc_enable),
        .early          (early),
        .prompt         (prompt),
        .late           (late)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    // Reference state: one epoch of chips in a table, indexed by half-chip phase.
    bit tab [0:1022];
    int m_cnt, m_pend, m_hold, m_phase;
    bit m_pend_vld, m_e, m_p, m_l, m_dump, m_fc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic build_tab(input logic [9:0] k);
        logic [9:0] a;
        logic [9:0] b;
        a = 10'h3FF;
        b = k;
        for (int i = 0; i < 1023; i++) begin
            tab[i] = a[0] ^ b[0];
            a = {a[7] ^ a[0], a[9:1]};
            b = {b[8] ^ b[7] ^ b[4] ^ b[2] ^ b[1] ^ b[0], b[9:1]};
        end
    endtask

    task automatic model_step();
        int c;
`ifdef CODE_GEN_PHASE_LATCH_EN
        if (rstn) m_phase = 0;
        else if (tic_enable) m_phase = m_cnt;
`endif
        if (rstn) begin
            m_cnt = 0; m_pend = 0; m_pend_vld = 0; m_hold = 0;
            m_e = 0; m_p = 0; m_l = 0; m_dump = 0; m_fc = 0;
            build_tab(10'h000);
        end else if (prn_key_enable) begin
            build_tab(prn_key);
            m_cnt = 0; m_pend_vld = 0; m_hold = 0; m_dump = 0; m_fc = 0;
        end else begin
            m_dump = 0;
            m_fc   = 0;
            if (hc_enable) begin
                if (m_hold > 0) begin
                    m_hold--;
                end else begin
                    c = m_cnt;
                    m_l = m_p;
                    m_p = m_e;
                    m_e = tab[c / 2];
                    m_fc = (c % 2 == 1);
                    if (c == HC - 1) begin
                        m_dump = 1;
                        m_cnt = 0;
                        if (m_pend_vld) begin
                            m_hold = m_pend;
                            m_pend_vld = 0;
                        end
                    end else begin
                        m_cnt = c + 1;
                    end
                end
            end
            if (slew_enable) begin
                m_pend_vld = 1;
                m_pend = (int'(code_slew) > HC) ? HC : int'(code_slew);
            end
        end
`ifndef CODE_GEN_PHASE_LATCH_EN
        m_phase = m_cnt;
`endif
    endtask

    task automatic compare_all();
        check("dump_enable", 32'(dump_enable), 32'(m_dump));
        check("fc_enable",   32'(fc_enable),   32'(m_fc));
        check("early",       32'(early),       32'(m_e));
        check("prompt",      32'(prompt),      32'(m_p));
        check("late",        32'(late),        32'(m_l));
        check("code_phase",  32'(code_phase),  32'(m_phase));
    endtask

    // Inputs set by the caller are applied for one clock; afterwards outputs reflect them.
    task automatic tick();
        model_step();
        @(negedge clk);
        cyc++;
        if (chk_on) compare_all();
        tic_enable = 1'b0;
        hc_enable = 1'b0;
        prn_key_enable = 1'b0;
        slew_enable = 1'b0;
        rstn = 1'b0;
    endtask

    initial begin
        logic [9:0] prn1_exp;
        int hcn, nfc, fc_t0, ndump;
        int d_t [3];
        prn1_exp = 10'b1100100000;
        hcn = 0; nfc = 0; fc_t0 = 0; ndump = 0;
        d_t[0] = 0; d_t[1] = 0; d_t[2] = 0;

        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk_on = 1'b1;
        rstn = 1'b1;
        tick();
        check("rst_dump",   32'(dump_enable), 32'd0);
        check("rst_prompt", 32'(prompt),      32'd0);
        check("rst_phase",  32'(code_phase),  32'd0);

        // PRN 1 with a 1023 half-chip slew pending, hc_enable every 8 clocks.
        prn_key = 10'h3EC;
        prn_key_enable = 1'b1;
        tick();
        code_slew = 11'd1023;
        slew_enable = 1'b1;
        tick();
        for (int i = 0; i < 58000 && ndump < 3; i++) begin
            bit cur;
            cur = (i % 8 == 0);
            hc_enable = cur;
            tick();
            if (cur) begin
                hcn++;
                if (hcn % 2 == 0 && hcn <= 20)
                    check("prn1_chip", 32'(prompt), 32'(prn1_exp[9 - (hcn - 2) / 2]));
            end
            if (fc_enable) begin
                nfc++;
                if (nfc == 1) fc_t0 = cyc;
                if (nfc == 2) check("fc_period", 32'(cyc - fc_t0), 32'd16);
            end
            if (dump_enable) begin
                d_t[ndump] = cyc;
                ndump++;
            end
        end
        check("dump_count", 32'(ndump), 32'd3);
        check("slew_epoch", 32'(d_t[1] - d_t[0]), 32'd24552);
        check("free_epoch", 32'(d_t[2] - d_t[1]), 32'd16368);

        // Reset in the middle of an epoch, then PRN 7.
        for (int i = 0; i < 400; i++) begin
            hc_enable = (i % 8 == 0);
            tick();
        end
        rstn = 1'b1;
        tick();
        check("midrst_dump",  32'(dump_enable), 32'd0);
        check("midrst_fc",    32'(fc_enable),   32'd0);
        check("midrst_early", 32'(early),       32'd0);
        check("midrst_late",  32'(late),        32'd0);
        prn_key = 10'h196;
        prn_key_enable = 1'b1;
        tick();
        hcn = 0;
        for (int i = 0; i < 24; i++) begin
            bit cur;
            cur = (i % 8 == 0);
            hc_enable = cur;
            tick();
            if (cur) begin
                hcn++;
                if (hcn == 2) check("prn7_first", 32'(prompt), 32'd1);
            end
        end

        // Key load coincident with hc_enable: the half-chip is not counted.
        for (int i = 0; i < 9; i++) begin
            hc_enable = 1'b1;
            tick();
        end
        prn_key = 10'h3EC;
        prn_key_enable = 1'b1;
        hc_enable = 1'b1;
        tick();
        check("keyhc_fc", 32'(fc_enable), 32'd0);
        hc_enable = 1'b1;
        tick();
        check("keyhc_even", 32'(fc_enable), 32'd0);
        hc_enable = 1'b1;
        tick();
        check("keyhc_odd", 32'(fc_enable), 32'd1);

        // Random traffic, starting with an over-range slew that must clamp.
        code_slew = 11'd2047;
        slew_enable = 1'b1;
        tick();
        for (int i = 0; i < 25000 && n_fail < 100; i++) begin
            hc_enable  = ($urandom_range(0, 1) == 1);
            tic_enable = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 299) == 0) begin
                slew_enable = 1'b1;
                code_slew = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1800, 2047))
                                                       : 11'($urandom_range(0, 200));
            end
            if ($urandom_range(0, 3999) == 0) begin
                prn_key_enable = 1'b1;
                prn_key = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 7999) == 0) rstn = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
